// File: rtl/conv_pkg.sv
// conv_pkg: FSM encoding, default geometry and output-size helper shared across the conv datapath
package conv_pkg;
   typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;
   localparam int XS_DEF     = 32;
   localparam int WS_DEF     = 5;
   localparam int STRIDE_DEF = 1;
   function automatic int calc_os(input int xs, input int ws, input int stride);
      return (xs - ws) / stride + 1;
   endfunction
endpackage

// File: rtl/out_requant.sv
// out_requant: arithmetic shift, optional ReLU and signed saturation from IW to OW bits
module out_requant #(
   parameter int IW    = 20,
   parameter int OW    = 8,
   parameter int SHIFT = 6,
   parameter int RELU  = 1
) (
   input  logic [IW-1:0] i_data,
   output logic [OW-1:0] o_data
);
   localparam logic signed [IW-1:0] MAXV = IW'((2 ** (OW - 1)) - 1);
   localparam logic signed [IW-1:0] MINV = ~MAXV;
   logic signed [IW-1:0] w_s;
   logic signed [IW-1:0] w_r;
   // shift down, drop negatives when ReLU is on, then clamp into the OW-bit range
   always_comb begin
      w_s    = $signed(i_data) >>> SHIFT;
      w_r    = (RELU != 0 && w_s[IW-1]) ? '0 : w_s;
      o_data = (w_r > MAXV) ? MAXV[OW-1:0] : (w_r < MINV) ? MINV[OW-1:0] : w_r[OW-1:0];
   end
endmodule

// File: rtl/conv_out_collector.sv
// conv_out_collector: requantises window results and writes them to the output map in raster order
module conv_out_collector
   import conv_pkg::*;
#(
   parameter int Xs     = XS_DEF,
   parameter int Ws     = WS_DEF,
   parameter int stride = STRIDE_DEF,
   parameter int IW     = 20,
   parameter int OW     = 8,
   parameter int SHIFT  = 6,
   parameter int RELU   = 1,
   parameter int AD     = 10
) (
   input  logic          iCLK,
   input  logic          iRSTn,
   input  logic          iStart,
   input  logic          iValid,
   input  logic [IW-1:0] iData,
   output logic          oWrEn,
   output logic [AD-1:0] oWrAddr,
   output logic [OW-1:0] oWrData,
   output logic          oBusy,
   output logic          oDone,
   output logic          oErr
);
   localparam int OS = calc_os(Xs, Ws, stride);
   localparam logic [AD-1:0] LAST = AD'(OS - 1);
   state_t        r_state, w_next;
   logic [AD-1:0] r_col, r_row, w_col, w_row, w_addr;
   logic          w_acc, w_last;
   logic [OW-1:0] w_px;
   logic          r_wr_en, r_err;
   logic [AD-1:0] r_wr_addr;
   logic [OW-1:0] r_wr_data;
   out_requant #(.IW(IW), .OW(OW), .SHIFT(SHIFT), .RELU(RELU)) u_rq (
      .i_data(iData),
      .o_data(w_px)
   );
   // accept decision; a start in the same cycle makes this pixel (0,0) of a fresh frame
   always_comb begin
      w_acc  = iValid && (r_state == COLLECT || (r_state == DONE && iStart));
      w_col  = iStart ? '0 : r_col;
      w_row  = iStart ? '0 : r_row;
      w_last = (w_col == LAST) && (w_row == LAST);
      w_addr = w_row * AD'(OS) + w_col;
   end
   // next state: IDLE and DONE both leave on start, COLLECT ends on the last pixel
   always_comb begin
      w_next = (r_state == COLLECT) ? ((w_acc && w_last) ? DONE : COLLECT) : (iStart ? COLLECT : IDLE);
   end
   // state register and raster counters
   always_ff @(posedge iCLK) begin
      if (!iRSTn) begin
         r_state <= IDLE;
         r_col   <= '0;
         r_row   <= '0;
      end else begin
         r_state <= w_next;
         if (w_acc) begin
            r_col <= (w_col == LAST) ? '0 : w_col + 1'b1;
            r_row <= w_last ? '0 : (w_col == LAST) ? w_row + 1'b1 : w_row;
         end else if (iStart) begin
            r_col <= '0;
            r_row <= '0;
         end
      end
   end
   // registered write port and sticky stray-valid flag
   always_ff @(posedge iCLK) begin
      if (!iRSTn) begin
         r_wr_en   <= 1'b0;
         r_wr_addr <= '0;
         r_wr_data <= '0;
         r_err     <= 1'b0;
      end else begin
         r_wr_en <= w_acc;
         if (w_acc) begin
            r_wr_addr <= w_addr;
            r_wr_data <= w_px;
         end
         r_err <= iStart ? 1'b0 : (iValid && r_state != COLLECT) ? 1'b1 : r_err;
      end
   end
   // state-decoded outputs
   always_comb begin
      oBusy = (r_state == COLLECT);
      oDone = (r_state == DONE);
   end
   assign oWrEn   = r_wr_en;
   assign oWrAddr = r_wr_addr;
   assign oWrData = r_wr_data;
   assign oErr    = r_err;
endmodule

// File: doc/conv_out_collector.md
Name: conv_out_collector

Overview:
- Consumer end of the convolution window stream. Takes the per-window valid pulse and its accumulator result from the window controller / MAC path.
- Rescales each result to the output precision and writes it into the output feature-map SRAM in raster order.
- Tracks output row/column, raises a done pulse per frame, and flags stray valids.
- Sits between the conv MAC array and the output buffer.

Parameters:
- Xs, 32, input feature-map side length (square).
- Ws, 5, kernel side length.
- stride, 1, window step in both directions.
- IW, 20, signed accumulator input width.
- OW, 8, signed output pixel width.
- SHIFT, 6, arithmetic right shift applied before saturation.
- RELU, 1, 1 = clamp negatives to 0 after the shift.
- AD, 10, write address width. Must satisfy 2^AD >= Os*Os.

Ports:
- iCLK, input, 1, clock.
- iRSTn, input, 1, reset, synchronous active-low.
- iStart, input, 1, one-cycle pulse that arms collection of one frame.
- iValid, input, 1, window result valid (driven by the window controller's oValid).
- iData, input, IW, signed accumulator result, qualified by iValid.
- oWrEn, output, 1, output SRAM write enable.
- oWrAddr, output, AD, output SRAM write address.
- oWrData, output, OW, signed rescaled pixel.
- oBusy, output, 1, high while in COLLECT.
- oDone, output, 1, one-cycle pulse when a frame is complete.
- oErr, output, 1, sticky flag: iValid arrived outside COLLECT.

Behaviour:
- Os = (Xs-Ws)/stride+1, an elaboration constant (28 at defaults). Output col and row counters are AD bits wide.
- Reset: iRSTn low at a rising edge (synchronous, active-low). State goes to IDLE; counters go to 0. oWrEn, oWrAddr, oWrData, oBusy, oDone and oErr are all 0.
- Reset mid-frame: the frame is aborted with no further writes and no oDone.
- FSM states: IDLE, COLLECT, DONE.
- IDLE:
  - iStart -> COLLECT; clear col/row and oErr.
  - iValid without iStart -> set oErr; no write.
- COLLECT:
  - Each iValid is accepted.
  - Write issued exactly 1 cycle later (registered): oWrEn=1, oWrAddr=row*Os+col, oWrData=sat(data).
  - After accept: col increments. At col==Os-1, col wraps to 0 and row increments.
  - Accept with row==Os-1 and col==Os-1 -> DONE; counters go to 0.
- DONE:
  - Lasts 1 cycle; oDone=1 in this cycle. oDone coincides with the final oWrEn.
  - DONE -> IDLE next cycle, or -> COLLECT if iStart is high in DONE (back-to-back frames).
  - iValid in DONE sets oErr.
- iStart while in COLLECT: restart. Counters clear, state stays COLLECT, no oDone.
  - If iValid arrives in the same cycle as that iStart, it is accepted as pixel (0,0) of the new frame.
- oErr: sticky; cleared only by reset or by iStart.
- Back-to-back iValid (every cycle) is sustained at 1 write/cycle. There is no backpressure.
- Arithmetic, rescaling iData:
  - s = iData >>> SHIFT (signed, IW bits).
  - If RELU and s<0, then s=0.
  - Clamp s to [-2^(OW-1), 2^(OW-1)-1]; output is the low OW bits.
  - With RELU, the result is in [0, 2^(OW-1)-1].
- oBusy=1 in COLLECT only.

Decomposition:
- Shared package (conv_pkg) holds:
  - the FSM state encoding (IDLE/COLLECT/DONE);
  - the Os computation, as a constant function of Xs/Ws/stride;
  - the default Xs/Ws/stride values.
- These are shared with the window controller and the input feeder.
- One sub-module: out_requant, a combinational shift/ReLU/saturate unit (IW -> OW) with parameters SHIFT, RELU. It is reused later by the pooling path.

Test Plan:
- Reset, then iStart, then 784 consecutive iValid with iData=k*64 (k=0..783) -> 784 writes. Addresses run 0..783 in order; oWrData=min(k,127). oDone pulses once, with the write to addr 783. oBusy falls the cycle after.
- Saturation with RELU=1, SHIFT=6:
  - iData=-640 -> 0.
  - iData=8191 (s=127) -> 127.
  - iData=8192 -> 127.
  - iData=0x7FFFF -> 127.
- With RELU=0, iData=-640 -> -10 (0xF6).
- Gapped valid: iValid every 3rd cycle for a full frame -> each write 1 cycle after its valid. Row wrap correct: the 29th valid -> oWrAddr=28. Single oDone.
- Stray/restart:
  - iValid in IDLE -> oErr=1, no oWrEn.
  - iStart -> oErr=0.
  - After 100 accepts, iStart -> next write addr=0, and no oDone for the aborted frame.
- iRSTn low for 1 cycle mid-frame (after 300 accepts) -> all outputs 0 next cycle, state IDLE. Later iValid sets oErr until iStart.
- Back-to-back frames: iStart asserted during DONE -> next accept writes addr 0 with no idle gap; two oDone pulses 784 valid-cycles apart.
